// File: rtl/e203_itcm_ifu_resp_pkg.sv
// Shared constants and helpers for the ITCM IFU response path.
//   ItcmAddrWidth / ItcmDataWidth / ItcmSize : default ITCM geometry.
//   ptr_width() / cnt_width()                : FIFO pointer and occupancy widths.
package e203_itcm_ifu_resp_pkg;

  localparam int unsigned ItcmAddrWidth = 16;
  localparam int unsigned ItcmDataWidth = 64;
  localparam int unsigned ItcmSize      = 65536;
  localparam int unsigned RspDepthDflt  = 2;

  // A single-entry FIFO still needs a 1-bit pointer to keep the vectors legal.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/e203_itcm_rsp_fifo.sv
// Synchronous response FIFO with occupancy count.
//   clk_i, rst_i : clock, asynchronous active-high reset (empties the FIFO)
//   push_i       : write wdata_i at the tail (caller guarantees not full)
//   pop_i        : drop the head entry (caller guarantees not empty)
//   rdata_o      : head entry
//   cnt_o        : number of stored entries
module e203_itcm_rsp_fifo
  import e203_itcm_ifu_resp_pkg::*;
#(
  parameter int unsigned Depth = 2,
  parameter int unsigned Width = 65
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         push_i,
  input  logic [Width-1:0]             wdata_i,
  input  logic                         pop_i,
  output logic [Width-1:0]             rdata_o,
  output logic [cnt_width(Depth)-1:0]  cnt_o
);

  localparam int unsigned PtrW = ptr_width(Depth);
  localparam int unsigned CntW = cnt_width(Depth);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_i) wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + PtrW'(1);
    if (pop_i)  rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + PtrW'(1);
    case ({push_i, pop_i})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage carries no reset; validity is tracked by cnt_q alone.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign cnt_o   = cnt_q;

endmodule

// File: rtl/e203_itcm_ifu_resp.sv
// ITCM-side ICB responder for IFU fetches.
//   icb_cmd_*  : IFU read command (valid/ready/addr)
//   icb_rsp_*  : in-order response (valid/ready/err/rdata), 1-cycle latency, buffered on stall
//   ifu_holdup_o : SRAM output still holds the last IFU fetch
//   arb_block_i  : another master owns the SRAM this cycle
//   ram_*        : single-port SRAM read interface (cs/addr out, dout in the next cycle)
module e203_itcm_ifu_resp
  import e203_itcm_ifu_resp_pkg::*;
#(
  parameter int unsigned ADDR_W    = ItcmAddrWidth,
  parameter int unsigned DATA_W    = ItcmDataWidth,
  parameter int unsigned SIZE_B    = ItcmSize,
  parameter int unsigned RSP_DEPTH = RspDepthDflt
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic                                 icb_cmd_valid_i,
  output logic                                 icb_cmd_ready_o,
  input  logic [ADDR_W-1:0]                    icb_cmd_addr_i,
  output logic                                 icb_rsp_valid_o,
  input  logic                                 icb_rsp_ready_i,
  output logic                                 icb_rsp_err_o,
  output logic [DATA_W-1:0]                    icb_rsp_rdata_o,
  output logic                                 ifu_holdup_o,
  input  logic                                 arb_block_i,
  output logic                                 ram_cs_o,
  output logic [ADDR_W-$clog2(DATA_W/8)-1:0]   ram_addr_o,
  input  logic [DATA_W-1:0]                    ram_dout_i
);

  localparam int unsigned Off  = $clog2(DATA_W / 8);
  localparam int unsigned CntW = cnt_width(RSP_DEPTH);
  localparam logic [ADDR_W:0] SizeLim  = (ADDR_W + 1)'(SIZE_B);
  localparam logic [CntW:0]   DepthLim = (CntW + 1)'(RSP_DEPTH);

  logic              inflight_q, err_q, holdup_q, holdup_d;
  logic [CntW-1:0]   buf_cnt;
  logic [CntW:0]     occ;
  logic [DATA_W:0]   buf_head;
  logic [DATA_W-1:0] new_data;
  logic              accept, in_range, buf_empty, push, pop, hold_set, hold_clr;

  // Occupancy counts the response still in flight so the buffer can never overflow.
  assign occ             = {1'b0, buf_cnt} + {{CntW{1'b0}}, inflight_q};
  assign icb_cmd_ready_o = ~rst_i & ~arb_block_i & (occ < DepthLim);
  assign accept          = icb_cmd_valid_i & icb_cmd_ready_o;
  assign in_range        = {1'b0, icb_cmd_addr_i} < SizeLim;

  assign ram_cs_o   = accept & in_range;
  assign ram_addr_o = icb_cmd_addr_i[ADDR_W-1:Off];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      inflight_q <= 1'b0;
      err_q      <= 1'b0;
      holdup_q   <= 1'b0;
    end else begin
      inflight_q <= accept;
      err_q      <= accept & ~in_range;
      holdup_q   <= holdup_d;
    end
  end

  // Clear wins over set.
  assign hold_set = ram_cs_o;
  assign hold_clr = arb_block_i | (accept & ~in_range);
  always_comb begin
    holdup_d = holdup_q;
    if (hold_clr)      holdup_d = 1'b0;
    else if (hold_set) holdup_d = 1'b1;
  end
  assign ifu_holdup_o = holdup_q;

  assign new_data  = err_q ? '0 : ram_dout_i;
  assign buf_empty = (buf_cnt == '0);
  // The fresh response bypasses the buffer only if it is empty and the IFU takes it now.
  assign push      = inflight_q & ~(buf_empty & icb_rsp_ready_i);
  assign pop       = ~buf_empty & icb_rsp_ready_i;

  e203_itcm_rsp_fifo #(
    .Depth (RSP_DEPTH),
    .Width (DATA_W + 1)
  ) u_rsp_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .wdata_i ({err_q, new_data}),
    .pop_i   (pop),
    .rdata_o (buf_head),
    .cnt_o   (buf_cnt)
  );

  always_comb begin
    icb_rsp_valid_o = 1'b0;
    icb_rsp_err_o   = 1'b0;
    icb_rsp_rdata_o = '0;
    if (!buf_empty) begin
      icb_rsp_valid_o = 1'b1;
      icb_rsp_err_o   = buf_head[DATA_W];
      icb_rsp_rdata_o = buf_head[DATA_W-1:0];
    end else if (inflight_q) begin
      icb_rsp_valid_o = 1'b1;
      icb_rsp_err_o   = err_q;
      icb_rsp_rdata_o = new_data;
    end
  end

endmodule

// File: tb/tb_e203_itcm_ifu_resp.sv
// Bench for e203_itcm_ifu_resp: directed scenarios followed by a random phase, all checked
// against a queue-based model of outstanding responses.
module tb_e203_itcm_ifu_resp;

  localparam int unsigned AddrW = 17;
  localparam int unsigned DataW = 64;
  localparam int unsigned SizeB = 65536;
  localparam int unsigned Depth = 2;

  typedef struct packed {
    logic        err;
    logic [63:0] data;
  } rsp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid, cmd_ready, rsp_valid, rsp_ready, rsp_err;
  logic [AddrW-1:0] cmd_addr;
  logic [DataW-1:0] rsp_rdata;
  logic             holdup, arb_block, ram_cs;
  logic [13:0]      ram_addr;
  logic [DataW-1:0] ram_dout = '0;

  rsp_t exp_q[$];
  logic hold_m;
  int   n_chk, n_fail, n_acc;

  always #5 clk = ~clk;

  e203_itcm_ifu_resp #(
    .ADDR_W    (AddrW),
    .DATA_W    (DataW),
    .SIZE_B    (SizeB),
    .RSP_DEPTH (Depth)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .icb_cmd_valid_i (cmd_valid),
    .icb_cmd_ready_o (cmd_ready),
    .icb_cmd_addr_i  (cmd_addr),
    .icb_rsp_valid_o (rsp_valid),
    .icb_rsp_ready_i (rsp_ready),
    .icb_rsp_err_o   (rsp_err),
    .icb_rsp_rdata_o (rsp_rdata),
    .ifu_holdup_o    (holdup),
    .arb_block_i     (arb_block),
    .ram_cs_o        (ram_cs),
    .ram_addr_o      (ram_addr),
    .ram_dout_i      (ram_dout)
  );

  function automatic logic [63:0] sram_word(input logic [13:0] w);
    if (w == 14'd1) return 64'hDEAD_BEEF_0123_4567;
    return {2'b10, w, 16'h5A5A, ~w, 2'b01, w, 2'b11};
  endfunction

  // SRAM: data appears the cycle after a strobe; another master's reads scramble the output.
  always @(posedge clk) begin
    if (ram_cs) ram_dout <= sram_word(ram_addr);
    else if (arb_block && ($urandom_range(0, 1) == 1)) ram_dout <= {$urandom(), $urandom()};
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive, check at the falling edge, advance the model at the rising edge.
  task automatic step(input logic v, input logic [16:0] a, input logic rr, input logic ab);
    rsp_t hd;
    logic rdy_m, acc_m, inr_m;
    cmd_valid = v;
    cmd_addr  = a;
    rsp_ready = rr;
    arb_block = ab;
    @(negedge clk);
    rdy_m = !ab && (exp_q.size() < Depth);
    acc_m = v && rdy_m;
    inr_m = 32'(a) < SizeB;
    check("cmd_ready", 64'(cmd_ready), 64'(rdy_m));
    check("ram_cs", 64'(ram_cs), 64'(acc_m && inr_m));
    if (acc_m && inr_m) check("ram_addr", 64'(ram_addr), 64'(32'(a) / 8));
    check("rsp_valid", 64'(rsp_valid), 64'(exp_q.size() > 0));
    if (exp_q.size() > 0) begin
      hd = exp_q[0];
      check("rsp_err", 64'(rsp_err), 64'(hd.err));
      check("rsp_rdata", rsp_rdata, hd.data);
    end else begin
      check("rdata_idle", rsp_rdata, 64'd0);
    end
    check("holdup", 64'(holdup), 64'(hold_m));
    @(posedge clk);
    if (exp_q.size() > 0 && rr) void'(exp_q.pop_front());
    if (acc_m) begin
      n_acc++;
      hd.err  = !inr_m;
      hd.data = inr_m ? sram_word(a[16:3]) : 64'd0;
      exp_q.push_back(hd);
    end
    if (ab || (acc_m && !inr_m)) hold_m = 1'b0;
    else if (acc_m)              hold_m = 1'b1;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    logic [16:0] a;
    n_chk = 0; n_fail = 0; n_acc = 0; hold_m = 1'b0;
    rst = 1'b1; cmd_valid = 1'b1; cmd_addr = 17'h8; rsp_ready = 1'b1; arb_block = 1'b0;
    #3;
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_holdup", 64'(holdup), 64'd0);
    check("rst_ram_cs", 64'(ram_cs), 64'd0);
    check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0; cmd_valid = 1'b0;

    // 1: single fetch
    step(1'b1, 17'h0008, 1'b1, 1'b0);
    step(1'b0, 17'h0, 1'b1, 1'b0);
    step(1'b0, 17'h0, 1'b1, 1'b0);

    // 2: four back-to-back fetches
    for (int i = 0; i < 4; i++) step(1'b1, 17'(i * 8), 1'b1, 1'b0);
    step(1'b0, 17'h0, 1'b1, 1'b0);

    // 3: IFU stalls; only two fetches fit, then drain in order
    base = n_acc;
    for (int i = 0; i < 5; i++) step(1'b1, 17'(16'h100 + i * 8), 1'b0, 1'b0);
    check("t3_accepts", 64'(n_acc - base), 64'd2);
    for (int i = 0; i < 6; i++) step(1'b1, 17'(16'h200 + i * 8), 1'b1, 1'b0);
    step(1'b0, 17'h0, 1'b1, 1'b0);

    // 4: out-of-range fetch after an in-range one, so holdup must drop
    step(1'b1, 17'h0040, 1'b1, 1'b0);
    step(1'b1, 17'h1_0000, 1'b1, 1'b0);
    step(1'b0, 17'h0, 1'b1, 1'b0);
    check("t4_holdup", 64'(holdup), 64'd0);

    // 5: holdup set by a read, cleared by arb_block and by a blocked same-cycle read
    step(1'b1, 17'h0080, 1'b1, 1'b0);
    step(1'b0, 17'h0, 1'b1, 1'b0);
    step(1'b0, 17'h0, 1'b1, 1'b1);
    step(1'b0, 17'h0, 1'b1, 1'b0);
    step(1'b1, 17'h0088, 1'b1, 1'b0);
    step(1'b1, 17'h0090, 1'b1, 1'b1);
    step(1'b0, 17'h0, 1'b1, 1'b0);

    // 6: reset with two buffered responses
    step(1'b1, 17'h0300, 1'b0, 1'b0);
    step(1'b1, 17'h0308, 1'b0, 1'b0);
    step(1'b0, 17'h0, 1'b0, 1'b0);
    cmd_valid = 1'b1;
    #1 rst = 1'b1;
    #1;
    check("t6_rsp_valid", 64'(rsp_valid), 64'd0);
    check("t6_cmd_ready", 64'(cmd_ready), 64'd0);
    check("t6_ram_cs", 64'(ram_cs), 64'd0);
    exp_q.delete();
    hold_m = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0; cmd_valid = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b0, 17'h0, 1'b1, 1'b0);
    step(1'b1, 17'h0008, 1'b1, 1'b0);
    step(1'b0, 17'h0, 1'b1, 1'b0);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      a = ($urandom_range(0, 7) == 0) ? 17'(32'h1_0000 + $urandom_range(0, 16'hFFFF))
                                      : 17'($urandom_range(0, 16'hFFFF));
      step($urandom_range(0, 3) != 0, a, $urandom_range(0, 3) != 0,
           $urandom_range(0, 7) == 0);
    end
    for (int i = 0; i < 4; i++) step(1'b0, 17'h0, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
